// File: rtl/ocm_noise_sampler_pkg.sv
// Shared types and constants for the CDF noise sampler: FSM states and the
// 64-bit Galois LFSR definition.
package ocm_noise_sampler_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DRAW = 3'd1,
      ADDR = 3'd2,
      CMP  = 3'd3,
      OUT  = 3'd4
   } state_t;

   // Right-shift Galois mask for x^64 + x^63 + x^61 + x^60 + 1.
   localparam logic [63:0] LFSR_TAPS         = 64'hD800_0000_0000_0000;
   localparam logic [63:0] LFSR_DEFAULT_SEED = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] LFSR_SAFE_SEED    = 64'h0000_0000_0000_0001;

   function automatic logic [63:0] lfsr_step(input logic [63:0] cur);
      return {1'b0, cur[63:1]} ^ (cur[0] ? LFSR_TAPS : 64'h0);
   endfunction

endpackage

// File: rtl/ocm_noise_sampler_lfsr64_galois.sv
// Free-running 64-bit Galois LFSR with a seed load that never admits the
// all-zero lock-up state.
module lfsr64_galois
   import ocm_noise_sampler_pkg::*;
#(
   parameter logic [63:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [63:0] load_value,
   output logic [63:0] state
);

   // LFSR register: reload has priority, otherwise step every clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= SEED;
      end else if (load) begin
         state <= (load_value == 64'h0) ? LFSR_SAFE_SEED : load_value;
      end else begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/ocm_noise_sampler.sv
// Draws a uniform value and binary-searches the CDF table held in the
// port-B memory, emitting index - OFFSET on a valid/ready stream.
module ocm_noise_sampler
   import ocm_noise_sampler_pkg::*;
#(
   parameter int          ADDR_W     = 14,
   parameter int          DATA_W     = 64,
   parameter int          TABLE_BASE = 0,
   parameter int          DEPTH_LOG2 = 8,
   parameter int          OUT_W      = 8,
   parameter int          OFFSET     = 128,
   parameter logic [63:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                rand_src_sel,
   input  logic [DATA_W-1:0]   ext_uniform,
   input  logic                seed_load,
   input  logic [63:0]         seed_value,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic [OUT_W-1:0]    sample_data,
   output logic                busy,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_clken,
   output logic [DATA_W-1:0]   mem_writedata,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int IW = DEPTH_LOG2 + 1;
   localparam int BW = (DEPTH_LOG2 > 1) ? $clog2(DEPTH_LOG2) : 1;
   localparam int N  = 1 << DEPTH_LOG2;

   localparam logic [IW-1:0]     IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]     IDX_N    = IW'(N);
   localparam logic [IW-1:0]     IDX_MAX  = IW'(N - 1);
   localparam logic [BW-1:0]     B_START  = BW'(DEPTH_LOG2 - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_r, state_nxt_s;
   logic [DATA_W-1:0]   u_r, u_nxt_s;
   logic [IW-1:0]       idx_r, idx_nxt_s, idx_clamp_s;
   logic [BW-1:0]       b_r, b_nxt_s;
   logic [IW-1:0]       step_s, step_nxt_s;
   logic [ADDR_W-1:0]   addr_s;
   logic [OUT_W-1:0]    sample_s;
   logic [63:0]         lfsr_s;

   lfsr64_galois #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (seed_load),
      .load_value (seed_value),
      .state      (lfsr_s)
   );

   assign step_s     = IDX_ONE << b_r;
   assign step_nxt_s = IDX_ONE << b_nxt_s;

   // Next-state and search datapath; each CMP step resolves one index bit.
   always_comb begin
      state_nxt_s = state_r;
      u_nxt_s     = u_r;
      idx_nxt_s   = idx_r;
      b_nxt_s     = b_r;
      case (state_r)
         IDLE: begin
            if (enable) state_nxt_s = DRAW;
            else        state_nxt_s = IDLE;
         end
         DRAW: begin
            u_nxt_s     = rand_src_sel ? ext_uniform : DATA_W'(lfsr_s);
            idx_nxt_s   = {IW{1'b0}};
            b_nxt_s     = B_START;
            state_nxt_s = ADDR;
         end
         ADDR: begin
            state_nxt_s = CMP;
         end
         CMP: begin
            if (mem_readdata < u_r) idx_nxt_s = idx_r + step_s;
            else                    idx_nxt_s = idx_r;
            if (b_r == {BW{1'b0}}) begin
               state_nxt_s = OUT;
            end else begin
               b_nxt_s     = b_r - {{(BW-1){1'b0}}, 1'b1};
               state_nxt_s = ADDR;
            end
         end
         OUT: begin
            if (sample_valid && sample_ready) state_nxt_s = enable ? DRAW : IDLE;
            else                              state_nxt_s = OUT;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Probe address for the coming ADDR cycle, and the clamped, centred result.
   always_comb begin
      addr_s = ADDR_W'(TABLE_BASE) + ADDR_W'(idx_nxt_s) + ADDR_W'(step_nxt_s) - ADDR_ONE;
      if (idx_nxt_s >= IDX_N) idx_clamp_s = IDX_MAX;
      else                    idx_clamp_s = idx_nxt_s;
      sample_s = OUT_W'(idx_clamp_s) - OUT_W'(OFFSET);
   end

   // FSM and search registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         u_r     <= {DATA_W{1'b0}};
         idx_r   <= {IW{1'b0}};
         b_r     <= {BW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         u_r     <= u_nxt_s;
         idx_r   <= idx_nxt_s;
         b_r     <= b_nxt_s;
      end
   end

   // Outputs are registered copies of the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_valid   <= 1'b0;
         sample_data    <= {OUT_W{1'b0}};
         busy           <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_address    <= {ADDR_W{1'b0}};
      end else begin
         sample_valid   <= (state_nxt_s == OUT);
         busy           <= (state_nxt_s != IDLE);
         mem_chipselect <= (state_nxt_s == ADDR);
         if (state_nxt_s == ADDR) mem_address <= addr_s;
         if ((state_r == CMP) && (state_nxt_s == OUT)) sample_data <= sample_s;
      end
   end

   assign mem_write      = 1'b0;
   assign mem_byteenable = {(DATA_W/8){1'b1}};
   assign mem_clken      = 1'b1;
   assign mem_writedata  = {DATA_W{1'b0}};

endmodule
